muldiv_sequencer: RTL and testbench



---
 rtl/muldiv_pkg.sv | 32 +++
 rtl/muldiv_step.sv | 40 ++++
 rtl/muldiv_sequencer.sv | 170 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and Funct3 decode helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic is_signed_a(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring compare-subtract-shift divide.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    i_div,
  input  logic [2*DATA_WIDTH-1:0] i_acc,
  input  logic [DATA_WIDTH-1:0]   i_b,
  output logic [2*DATA_WIDTH-1:0] o_acc
);

  localparam int W = DATA_WIDTH;

  logic [W-1:0] w_hi;
  logic [W-1:0] w_lo;
  logic [W:0]   w_sum;
  logic [W:0]   w_shift;
  logic         w_ge;
  logic [W-1:0] w_diff;

  assign w_hi = i_acc[2*W-1:W];
  assign w_lo = i_acc[W-1:0];

  // Multiply: low half holds the multiplier, consumed LSB first while the product shifts in from the top.
  assign w_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, i_b} : {(W+1){1'b0}});

  // Divide: high half is the partial remainder, low half shifts dividend out and quotient bits in.
  assign w_shift = {w_hi, w_lo[W-1]};
  assign w_ge    = w_shift >= {1'b0, i_b};
  assign w_diff  = w_shift[W-1:0] - i_b;

  always_comb begin
    o_acc = {w_sum, w_lo[W-1:1]};
    if (i_div) begin
      o_acc = {(w_ge ? w_diff : w_shift[W-1:0]), w_lo[W-2:0], w_ge};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer (IDLE -> CALC -> FIX -> DONE), one bit per cycle.
// Optional macro FAST_ZERO_EN: zero operands, divide-by-zero and signed overflow skip CALC.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic                  Flush,
  input  logic [2:0]            Funct3,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] Result
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);

  state_t             r_state;
  state_t             w_next;
  logic [2:0]         r_f3;
  logic [CNT_W-1:0]   r_cnt;
  logic [W-1:0]       r_b;
  logic [2*W-1:0]     r_acc;
  logic               r_neg;
  logic [W-1:0]       r_result;

  logic               w_accept;
  logic               w_a_neg;
  logic               w_b_neg;
  logic               w_neg;
  logic               w_fast;
  logic               w_is_div;
  logic [W-1:0]       w_mag_a;
  logic [W-1:0]       w_mag_b;
  logic [2*W-1:0]     w_load_acc;
  logic [2*W-1:0]     w_step_acc;
  logic [2*W-1:0]     w_prod;
  logic [W-1:0]       w_quo;
  logic [W-1:0]       w_rem;
  logic [W-1:0]       w_fix_val;

  assign w_accept = Start && !Flush;
  assign w_a_neg  = is_signed_a(Funct3) && SrcA[W-1];
  assign w_b_neg  = is_signed_b(Funct3) && SrcB[W-1];
  assign w_mag_a  = w_a_neg ? -SrcA : SrcA;
  assign w_mag_b  = w_b_neg ? -SrcB : SrcB;

  // Remainder follows the dividend; a zero divisor leaves the all-ones quotient un-negated.
  assign w_neg = is_div(Funct3)
               ? (Funct3[1] ? w_a_neg : ((w_a_neg ^ w_b_neg) && (SrcB != '0)))
               : (w_a_neg ^ w_b_neg);

`ifdef FAST_ZERO_EN
  logic w_ovf;
  assign w_ovf  = is_div(Funct3) && is_signed_b(Funct3) &&
                  (SrcA == {1'b1, {(W-1){1'b0}}}) && (SrcB == '1);
  assign w_fast = is_div(Funct3) ? ((SrcB == '0) || w_ovf) : ((SrcA == '0) || (SrcB == '0));

  // Preload the accumulator with exactly what the full iteration would have produced.
  always_comb begin
    w_load_acc = {{W{1'b0}}, w_mag_a};
    if (!is_div(Funct3) && w_fast) begin
      w_load_acc = '0;
    end else if (is_div(Funct3) && (SrcB == '0)) begin
      w_load_acc = {w_mag_a, {W{1'b1}}};
    end
  end
`else
  assign w_fast     = 1'b0;
  assign w_load_acc = {{W{1'b0}}, w_mag_a};
`endif

  assign w_is_div = is_div(r_f3);

  muldiv_step #(
    .DATA_WIDTH(W)
  ) u_step (
    .i_div (w_is_div),
    .i_acc (r_acc),
    .i_b   (r_b),
    .o_acc (w_step_acc)
  );

  assign w_prod = r_neg ? -r_acc : r_acc;
  assign w_quo  = r_neg ? -r_acc[W-1:0] : r_acc[W-1:0];
  assign w_rem  = r_neg ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];

  always_comb begin
    w_fix_val = w_prod[2*W-1:W];
    if (w_is_div) begin
      w_fix_val = r_f3[1] ? w_rem : w_quo;
    end else if (r_f3 == F3_MUL) begin
      w_fix_val = w_prod[W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next = w_fast ? ST_FIX : ST_CALC;
        end
      end
      ST_CALC: begin
        if (Flush) begin
          w_next = ST_IDLE;
        end else if (r_cnt == CNT_W'(DATA_WIDTH - 1)) begin
          w_next = ST_FIX;
        end
      end
      ST_FIX:  w_next = Flush ? ST_IDLE : ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_f3     <= '0;
      r_cnt    <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_f3  <= Funct3;
            r_b   <= w_mag_b;
            r_acc <= w_load_acc;
            r_neg <= w_neg;
            r_cnt <= '0;
          end
        end
        ST_CALC: begin
          if (!Flush) begin
            r_acc <= w_step_acc;
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_FIX: begin
          if (!Flush) begin
            r_result <= w_fix_val;
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy   = (r_state != ST_IDLE);
  assign Done   = (r_state == ST_DONE);
  assign Result = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed table, corner sequences, randomized ops vs reference model.
module tb_muldiv_sequencer;

  localparam int W        = 32;
  localparam int FULL_LAT = W + 1;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  logic        clk    = 1'b0;
  logic        reset  = 1'b1;
  logic        Start  = 1'b0;
  logic        Flush  = 1'b0;
  logic [2:0]  Funct3 = 3'd0;
  logic [31:0] SrcA   = 32'd0;
  logic [31:0] SrcB   = 32'd0;
  logic        Busy;
  logic        Done;
  logic [31:0] Result;

  int checkCount = 0;
  int passCount  = 0;

  muldiv_sequencer #(.DATA_WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .Start  (Start),
    .Flush  (Flush),
    .Funct3 (Funct3),
    .SrcA   (SrcA),
    .SrcB   (SrcB),
    .Busy   (Busy),
    .Done   (Done),
    .Result (Result)
  );

  always #5 clk = ~clk;

  // RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] refModel(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ub;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      OP_MUL:    begin p = 64'(sa * sb); return p[31:0];  end
      OP_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      OP_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
      OP_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      OP_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = 64'(sa / sb);
        return p[31:0];
      end
      OP_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : (a / b);
      OP_REM: begin
        if (b == 32'd0) return a;
        if (ovf) return 32'd0;
        p = 64'(sa % sb);
        return p[31:0];
      end
      default:   return (b == 32'd0) ? a : (a % b);
    endcase
  endfunction

  function automatic logic isFast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return (a == 32'd0) || (b == 32'd0);
    if (b == 32'd0) return 1'b1;
    return ((f3 == OP_DIV) || (f3 == OP_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic startOp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    Funct3 = f3;
    SrcA   = a;
    SrcB   = b;
    Start  = 1'b1;
    @(posedge clk);
    #1;
    Start  = 1'b0;
  endtask

  // Counts edges until Done is seen; -1 when the bound expires.
  task automatic waitDone(output int edges);
    edges = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (Done) begin
        edges = n;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input string name, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expected);
    int edges;
    startOp(f3, a, b);
    waitDone(edges);
`ifdef FAST_ZERO_EN
    if (isFast(f3, a, b)) begin
      checkOutput({name, " fast latency ok"}, {31'd0, (edges >= 1) && (edges <= 2)}, 32'd1);
    end else begin
      checkOutput({name, " latency"}, 32'(edges), 32'(FULL_LAT));
    end
`else
    checkOutput({name, " latency"}, 32'(edges), 32'(FULL_LAT));
`endif
    checkOutput({name, " result"}, Result, expected);
    @(posedge clk);
    #1;
    checkOutput({name, " busy/done after"}, {30'd0, Busy, Done}, 32'd0);
  endtask

  initial begin
    vec_t vecs[14];
    int   edges;
    bit   sawDone;
    logic [2:0]  rf3;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0]  = '{OP_MUL,    32'd7,          32'd6,          32'h0000_002A};
    vecs[1]  = '{OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000};
    vecs[2]  = '{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE};
    vecs[3]  = '{OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF};
    vecs[4]  = '{OP_DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
    vecs[5]  = '{OP_REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
    vecs[6]  = '{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
    vecs[7]  = '{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000};
    vecs[8]  = '{OP_DIVU,   32'd13,         32'd0,          32'hFFFF_FFFF};
    vecs[9]  = '{OP_REMU,   32'd13,         32'd0,          32'd13};
    vecs[10] = '{OP_DIV,    32'd5,          32'd0,          32'hFFFF_FFFF};
    vecs[11] = '{OP_REM,    32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB};
    vecs[12] = '{OP_MUL,    32'd0,          32'd12345,      32'd0};
    vecs[13] = '{OP_MULHU,  32'h8000_0000,  32'd2,          32'd1};

    repeat (3) @(negedge clk);
    checkOutput("reset busy/done", {30'd0, Busy, Done}, 32'd0);
    checkOutput("reset result", Result, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle after reset busy", {31'd0, Busy}, 32'd0);

    for (int i = 0; i < 14; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp);
    end

    // Flush during CALC iteration 10: abort silently, Result keeps the previous value.
    applyStimulus("pre-flush", OP_MUL, 32'd3, 32'd3, 32'd9);
    startOp(OP_DIVU, 32'd1000, 32'd7);
    repeat (10) @(posedge clk);
    @(negedge clk);
    Flush = 1'b1;
    @(posedge clk);
    #1;
    Flush = 1'b0;
    checkOutput("flush busy/done", {30'd0, Busy, Done}, 32'd0);
    checkOutput("flush result held", Result, 32'd9);
    sawDone = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (Done) sawDone = 1'b1;
    end
    checkOutput("no done after flush", {31'd0, sawDone}, 32'd0);
    applyStimulus("after flush", OP_DIVU, 32'd1000, 32'd7, 32'd142);

    // A second Start while busy must be ignored.
    startOp(OP_DIVU, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    Funct3 = OP_MUL;
    SrcA   = 32'd2;
    SrcB   = 32'd2;
    Start  = 1'b1;
    @(posedge clk);
    #1;
    Start  = 1'b0;
    waitDone(edges);
    checkOutput("start-while-busy latency", 32'(edges), 32'(FULL_LAT - 5));
    checkOutput("start-while-busy result", Result, 32'd14);
    @(posedge clk);
    #1;
    checkOutput("start-while-busy idle", {30'd0, Busy, Done}, 32'd0);

    // Flush during DONE still shows the pulse.
    startOp(OP_MUL, 32'd5, 32'd5);
    waitDone(edges);
    Flush = 1'b1;
    #1;
    checkOutput("flush-in-done pulse", {31'd0, Done}, 32'd1);
    @(posedge clk);
    #1;
    Flush = 1'b0;
    checkOutput("flush-in-done idle", {31'd0, Busy}, 32'd0);
    checkOutput("flush-in-done result", Result, 32'd25);

    // Start together with Flush in IDLE is dropped.
    @(negedge clk);
    Start = 1'b1;
    Flush = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    Flush = 1'b0;
    checkOutput("start+flush ignored", {31'd0, Busy}, 32'd0);

    // Asynchronous reset mid-CALC clears everything at once.
    startOp(OP_MUL, 32'd123, 32'd456);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("mid-op reset busy/done", {30'd0, Busy, Done}, 32'd0);
    checkOutput("mid-op reset result", Result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus("after reset", OP_REMU, 32'd100, 32'd7, 32'd2);

    for (int i = 0; i < 40; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = pickOperand();
      rb  = pickOperand();
      applyStimulus($sformatf("rand%0d f3=%0d a=%08h b=%08h", i, rf3, ra, rb), rf3, ra, rb, refModel(rf3, ra, rb));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
